// File: rtl/timer_tone_sequencer.sv
// timer_tone_sequencer: queues notes and plays them on a PWM interval timer through its Avalon-MM slave
module timer_tone_sequencer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DUR_W       = 16,
  parameter int REST_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [31:0]      note_period,
  input  logic [DUR_W-1:0] note_dur,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [2:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [15:0]      m_writedata,
  input  logic             timer_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = REST_CYCLES > 1 ? $clog2(REST_CYCLES) : 1;
  localparam logic [CW-1:0] REST_MAX = CW'(REST_CYCLES - 1);
  localparam logic [3:0] IDLE = 4'd0, LOAD_L = 4'd1, LOAD_H = 4'd2, CLR0 = 4'd3, START = 4'd4,
                         PLAY = 4'd5, CLEAR = 4'd6, REST_STOP = 4'd7, REST = 4'd8, HALT = 4'd9;
  logic [31:0]      q_period [FIFO_DEPTH];
  logic [DUR_W-1:0] q_dur [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [3:0]       state, nxt, after_note;
  logic [31:0]      period, nxt_period;
  logic [DUR_W-1:0] remaining, head_dur;
  logic [CW-1:0]    rest_cnt;
  logic             empty, push, pop, drain, wr, abort, rest_wrap;
  assign empty      = count == '0;
  assign note_ready = count != (AW+1)'(FIFO_DEPTH) && !stop;
  assign push       = note_valid && note_ready;
  assign busy       = state != IDLE;
  assign head_dur   = q_dur[rd_ptr];
  assign rest_wrap  = state == REST && rest_cnt == '0;
  assign abort      = stop && state != IDLE && state != HALT;
  // Where a finished note goes next: straight into the queued note, or stop the timer
  assign after_note = empty ? HALT : q_period[rd_ptr] != '0 ? LOAD_L : REST_STOP;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = empty || stop ? IDLE : after_note;
      LOAD_L:    nxt = LOAD_H;
      LOAD_H:    nxt = CLR0;
      CLR0:      nxt = START;
      START:     nxt = PLAY;
      PLAY:      nxt = timer_irq ? CLEAR : PLAY;
      CLEAR:     nxt = remaining != '0 ? PLAY : after_note;
      REST_STOP: nxt = REST;
      REST:      nxt = rest_wrap && remaining == DUR_W'(1) ? after_note : REST;
      default:   nxt = IDLE;
    endcase
    if (abort) nxt = HALT;
  end
  assign pop        = nxt == LOAD_L || nxt == REST_STOP;
  assign drain      = nxt == HALT && !abort;
  assign nxt_period = pop ? q_period[rd_ptr] : period;
  assign wr         = !(nxt == IDLE || nxt == PLAY || nxt == REST);
  always_ff @(posedge clk)
    if (push) begin
      q_period[wr_ptr] <= note_period;
      q_dur[wr_ptr]    <= note_dur;
    end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      period       <= '0;
      remaining    <= '0;
      rest_cnt     <= '0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= 3'd0;
      m_writedata  <= 16'h0;
      done         <= 1'b0;
    end else begin
      state     <= nxt;
      wr_ptr    <= stop ? '0 : wr_ptr + AW'(push);
      rd_ptr    <= stop ? '0 : rd_ptr + AW'(pop);
      count     <= stop ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
      period    <= nxt_period;
      remaining <= pop ? (head_dur == '0 ? DUR_W'(1) : head_dur) :
                   (state == PLAY && timer_irq) || rest_wrap ? remaining - DUR_W'(1) : remaining;
      rest_cnt  <= state == REST_STOP || rest_wrap ? REST_MAX : state == REST ? rest_cnt - CW'(1) : rest_cnt;
      m_chipselect <= wr;
      m_write_n    <= !wr;
      m_address    <= nxt == LOAD_L ? 3'd2 : nxt == LOAD_H ? 3'd3 :
                      nxt == START || nxt == REST_STOP || nxt == HALT ? 3'd1 : 3'd0;
      m_writedata  <= nxt == LOAD_L ? nxt_period[15:0] : nxt == LOAD_H ? period[31:16] :
                      nxt == START ? 16'h0007 : nxt == REST_STOP || nxt == HALT ? 16'h0008 : 16'h0000;
      done         <= drain;
    end
  end
endmodule

// File: tb/tb_timer_tone_sequencer.sv
// tb_timer_tone_sequencer: directed bench with an output-trace model of the note sequencer
module tb_timer_tone_sequencer;
  localparam int DEPTH = 8;
  localparam int RC = 4;
  logic clk = 1'b0, reset = 1'b1, note_valid = 1'b0, stop = 1'b0, timer_irq = 1'b0;
  logic [31:0] note_period = 32'h0;
  logic [15:0] note_dur = 16'h0;
  logic note_ready, busy, done, m_chipselect, m_write_n;
  logic [2:0] m_address;
  logic [15:0] m_writedata;
  timer_tone_sequencer #(.FIFO_DEPTH(DEPTH), .DUR_W(16), .REST_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_ready(note_ready),
    .note_period(note_period), .note_dur(note_dur), .stop(stop), .busy(busy), .done(done),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .timer_irq(timer_irq));
  always #5 clk = ~clk;
  typedef struct packed {logic wr; logic [2:0] a; logic [15:0] d; logic dn;} out_t;
  typedef struct {logic [31:0] p; int d;} note_t;
  typedef enum {M_IDLE, M_SEQ, M_PLAY, M_CLR, M_HALT} mode_t;
  mode_t mode = M_IDLE;
  out_t exp_o = '0;
  out_t ag[$];
  note_t nq[$];
  bit after_play, m_push, chk_en;
  int rem, mdone, ddone, checks, failures;
  logic [18:0] mlog[$], dlog[$], exp_log[$];
  function automatic out_t wr_o(input logic [2:0] a, input logic [15:0] d);
    return {1'b1, a, d, 1'b0};
  endfunction
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, a, e);
    end
  endtask
  // The model thinks in whole notes: each one expands into the bus-cycle trace it must produce
  task automatic next_note();
    note_t n;
    int r;
    if (nq.size() == 0) begin
      mode = M_HALT;
      exp_o = {1'b1, 3'd1, 16'h0008, 1'b1};
      return;
    end
    n = nq.pop_front();
    r = n.d == 0 ? 1 : n.d;
    ag.delete();
    if (n.p != 0) begin
      ag.push_back(wr_o(3'd2, n.p[15:0]));
      ag.push_back(wr_o(3'd3, n.p[31:16]));
      ag.push_back(wr_o(3'd0, 16'h0));
      ag.push_back(wr_o(3'd1, 16'h0007));
      after_play = 1'b1;
      rem = r;
    end else begin
      ag.push_back(wr_o(3'd1, 16'h0008));
      for (int i = 0; i < r * RC; i++) ag.push_back('0);
      after_play = 1'b0;
    end
    mode = M_SEQ;
    exp_o = ag.pop_front();
  endtask
  always @(posedge clk) begin
    if (reset) begin
      nq.delete();
      ag.delete();
      mode = M_IDLE;
      exp_o = '0;
    end else begin
      m_push = note_valid && nq.size() < DEPTH && !stop;
      if (stop) begin
        nq.delete();
        ag.delete();
        if (mode == M_IDLE || mode == M_HALT) begin
          mode = M_IDLE;
          exp_o = '0;
        end else begin
          mode = M_HALT;
          exp_o = wr_o(3'd1, 16'h0008);
        end
      end else
        case (mode)
          M_IDLE: if (nq.size() != 0) next_note(); else exp_o = '0;
          M_SEQ:
            if (ag.size() != 0) exp_o = ag.pop_front();
            else if (after_play) begin mode = M_PLAY; exp_o = '0; end
            else next_note();
          M_PLAY:
            if (timer_irq) begin rem--; mode = M_CLR; exp_o = wr_o(3'd0, 16'h0); end
            else exp_o = '0;
          M_CLR: if (rem != 0) begin mode = M_PLAY; exp_o = '0; end else next_note();
          default: begin mode = M_IDLE; exp_o = '0; end
        endcase
      if (m_push) nq.push_back('{note_period, int'(note_dur)});
      if (exp_o.wr) mlog.push_back({exp_o.a, exp_o.d});
      if (exp_o.dn) mdone++;
    end
  end
  always @(negedge clk)
    if (chk_en) begin
      chk("cycle", 64'({m_chipselect, m_write_n, m_address, m_writedata, done, busy, note_ready}),
          64'({exp_o.wr, !exp_o.wr, exp_o.a, exp_o.d, exp_o.dn, mode != M_IDLE, nq.size() < DEPTH && !stop}));
      if (m_chipselect) dlog.push_back({m_address, m_writedata});
      if (done) ddone++;
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic push(input logic [31:0] p, input logic [15:0] d);
    note_valid = 1'b1;
    note_period = p;
    note_dur = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (note_ready) begin
        @(posedge clk);
        #2;
        note_valid = 1'b0;
        return;
      end
    end
    note_valid = 1'b0;
    chk("push_timeout", 64'(0), 64'(1));
  endtask
  task automatic irq_pulse();
    timer_irq = 1'b1;
    tick(1);
    timer_irq = 1'b0;
  endtask
  task automatic stop_pulse();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask
  task automatic wait_idle(input string nm);
    int k = 0;
    tick(2);
    while (busy && k < 500) begin tick(1); k++; end
    chk({nm, " idle_timeout"}, 64'(busy), 64'(0));
  endtask
  task automatic clr();
    mlog.delete();
    dlog.delete();
    mdone = 0;
    ddone = 0;
  endtask
  task automatic check_log(input string nm, input int dn);
    chk({nm, " model_len"}, 64'(mlog.size()), 64'(exp_log.size()));
    chk({nm, " dut_len"}, 64'(dlog.size()), 64'(exp_log.size()));
    foreach (exp_log[i]) begin
      chk($sformatf("%s model_w%0d", nm, i), 64'(i < mlog.size() ? mlog[i] : 19'h7FFFF), 64'(exp_log[i]));
      chk($sformatf("%s dut_w%0d", nm, i), 64'(i < dlog.size() ? dlog[i] : 19'h7FFFF), 64'(exp_log[i]));
    end
    chk({nm, " model_done"}, 64'(mdone), 64'(dn));
    chk({nm, " dut_done"}, 64'(ddone), 64'(dn));
  endtask
  initial begin
    tick(2);
    chk_en = 1'b1;
    chk("rst_outputs", 64'({m_chipselect, m_write_n, m_address, m_writedata, done, busy, note_ready}),
        64'({1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1}));
    reset = 1'b0;
    tick(1);
    clr();
    push(32'h000186A0, 16'd3);
    tick(8); irq_pulse(); tick(3); irq_pulse(); tick(3); irq_pulse();
    wait_idle("single");
    exp_log = '{19'h286A0, 19'h30001, 19'h00000, 19'h10007, 19'h00000, 19'h00000, 19'h00000, 19'h10008};
    check_log("single", 1);
    clr();
    push(32'h00000100, 16'd1);
    push(32'h00000200, 16'd1);
    tick(8); irq_pulse(); tick(9); irq_pulse();
    wait_idle("b2b");
    exp_log = '{19'h20100, 19'h30000, 19'h00000, 19'h10007, 19'h00000,
                19'h20200, 19'h30000, 19'h00000, 19'h10007, 19'h00000, 19'h10008};
    check_log("b2b", 1);
    clr();
    for (int i = 0; i < 9; i++) push(32'h00000040, 16'd1);
    note_valid = 1'b1;
    note_period = 32'h00000777;
    tick(5);
    chk("full_ready", 64'(note_ready), 64'(0));
    note_valid = 1'b0;
    irq_pulse(); tick(3); stop_pulse();
    wait_idle("full");
    exp_log = '{19'h20040, 19'h30000, 19'h00000, 19'h10007, 19'h00000,
                19'h20040, 19'h30000, 19'h00000, 19'h10008};
    check_log("full", 0);
    clr();
    for (int i = 0; i < 5; i++) push(32'h00000300, 16'd1);
    tick(3); stop_pulse();
    wait_idle("stop");
    tick(10);
    exp_log = '{19'h20300, 19'h30000, 19'h00000, 19'h10007, 19'h10008};
    check_log("stop", 0);
    clr();
    push(32'h0, 16'd2);
    wait_idle("rest");
    exp_log = '{19'h10008, 19'h10008};
    check_log("rest", 1);
    clr();
    push(32'h00000050, 16'd0);
    irq_pulse(); tick(6); irq_pulse();
    wait_idle("dur0");
    exp_log = '{19'h20050, 19'h30000, 19'h00000, 19'h10007, 19'h00000, 19'h10008};
    check_log("dur0", 1);
    clr();
    push(32'h12345678, 16'd1);
    push(32'h00000099, 16'd1);
    tick(1);
    chk("load_h_addr", 64'(m_address), 64'(3));
    reset = 1'b1;
    tick(1);
    chk("mid_rst_outputs", 64'({m_chipselect, m_write_n, m_address, m_writedata, done, busy, note_ready}),
        64'({1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1}));
    reset = 1'b0;
    tick(10);
    exp_log = '{19'h25678, 19'h31234};
    check_log("reset", 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/timer_tone_sequencer.md
# timer_tone_sequencer

Note-playback controller for the PWM interval timer in the jukebox audio path. Accepts a queue of notes (timer period + duration in timer periods). For each note it programs the timer's 16-bit Avalon-MM slave: period low/high, clear status, start continuous with IRQ enabled. It then counts timer timeouts and, when the note's duration expires, moves to the next note or stops the timer. It sits between the Nios-side note writer and the timer slave port, which it owns exclusively.

## Interface
- FIFO_DEPTH, 8, note queue depth; power of two, ≥2
- DUR_W, 16, width of note duration
- REST_CYCLES, 50000, clk cycles per duration unit for a rest note (period = 0); ≥1
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- note_valid  in  1  note offered
- note_ready  out  1  queue can accept; transfer when note_valid & note_ready
- note_period  in  32  timer period value; 0 = rest
- note_dur  in  DUR_W  duration in timeouts (tone) or REST_CYCLES units (rest); 0 treated as 1
- stop  in  1  abort pulse: flush queue, stop timer
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the queue drains normally
- m_address  out  3  timer register address
- m_chipselect  out  1  timer chipselect
- m_write_n  out  1  timer write strobe, active-low
- m_writedata  out  16  timer write data
- timer_irq  in  1  timer interrupt (level, cleared by status write)

## Operation
- Queue: FIFO_DEPTH × (32+DUR_W). note_ready = !full. A pop in the same cycle does not raise ready. note_ready = 0 while stop = 1; pushes are ignored in that cycle.
- FSM states: IDLE, LOAD_L, LOAD_H, CLR0, START, PLAY, CLEAR, REST_STOP, REST, HALT.
- IDLE with queue non-empty: pop head into period/remaining registers (remaining = max(dur,1)).
  - Go to LOAD_L if period ≠ 0, else REST_STOP.
- Bus writes are one per state, one cycle each (m_chipselect=1, m_write_n=0):
  - LOAD_L: addr 2, period[15:0]
  - LOAD_H: addr 3, period[31:16]
  - CLR0: addr 0, 0x0000
  - START: addr 1, 0x0007 (START|CONT|ITO)
  - CLEAR: addr 0, 0x0000
  - REST_STOP: addr 1, 0x0008
  - HALT: addr 1, 0x0008
- Write-state transitions: LOAD_L→LOAD_H→CLR0→START→PLAY. REST_STOP→REST.
- PLAY: no bus activity; on timer_irq=1 → CLEAR with remaining decremented.
- CLEAR exit:
  - remaining ≠ 0 → PLAY.
  - remaining = 0 and queue non-empty → pop directly and go to LOAD_L or REST_STOP. No stop write between notes.
  - remaining = 0 and queue empty → HALT.
- REST: cycle counter runs REST_CYCLES−1…0. Each wrap decrements remaining. At remaining = 0 it takes the same next-note/HALT choice as CLEAR.
- HALT → IDLE. done pulses in the HALT cycle only when reached by draining.
- stop (any state except IDLE/HALT): flush the queue → HALT next cycle. done stays 0. stop in IDLE or HALT: flush only.
- timer_irq is ignored outside PLAY.
- Non-write cycles drive m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.

## Timing
- Reset values: state IDLE, queue empty, note_ready=1, busy=0, done=0, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, counters 0.
- Reset mid-operation returns to these values on the next edge. The timer itself is not written, so software must stop it or reset the system.
- Bus outputs are registered (Moore); the timer samples them at the edge ending the state.
- Latency: note accepted at edge E0 → IDLE pop at E1 → LOAD_L drives the bus during cycle E1–E2. Four tone writes occupy four consecutive cycles; PLAY is entered at E5.
- The timer clears its IRQ at the edge ending CLEAR, so PLAY never re-sees the same timeout.
- Note-to-note gap: CLEAR → LOAD_L, zero idle cycles.
- Rest duration: exactly remaining × REST_CYCLES cycles in REST.

## Test plan
- Single tone, period 0x000186A0, dur 3; pulse timer_irq 3× → bus writes (2,0x86A0), (3,0x0001), (0,0), (1,0x0007). Each irq is followed by exactly one (0,0). After the third comes (1,0x0008); done is 1 in that cycle, then busy=0.
- Two tones back-to-back (0x100 dur 1, 0x200 dur 1) → after the first irq: (0,0), (2,0x0200), (3,0), (0,0), (1,0x0007); no 0x0008 until the end.
- Hold timer_irq low in PLAY and push 9 notes with FIFO_DEPTH=8 → one in service plus 8 queued; note_ready=0 and the 10th offer is held. Each consumed note raises note_ready one cycle later.
- stop asserted in PLAY with 4 queued → next cycle (1,0x0008), queue empty, busy=0 after, done never 1, no further writes.
- Rest note period 0, dur 2, REST_CYCLES=4 → (1,0x0008), then exactly 8 cycles with no bus activity, then HALT write and done.
- dur 0 tone → behaves as dur 1. reset asserted during LOAD_H → all outputs at reset values next cycle and the queue is empty.
